rdysetgo_seq: RTL and testbench

Parametrised start-of-round display sequencer for the Simon Says 7-segment display. On a rising edge of start, it steps through a timed sequence of frames and then signals the game FSM. Each frame lasts a programmable number of clock cycles. MODE 0 shows "rdy" then "GO"; MODE 1 shows a numeric countdown from COUNT_FROM to 1, then "GO". It drives the per-digit code bus and blank mask consumed by the existing segment decoder/mux.

---
 rtl/rdysetgo_pkg.sv | 24 ++
 rtl/rdysetgo_frame_rom.sv | 59 +++++
 rtl/rdysetgo_seq.sv | 133 +++++++++++++
 tb/tb_rdysetgo_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rdysetgo_pkg.sv
// Shared constants for the ready/set/go display sequencer: glyph codes,
// frame-set selectors and the sequencer state encoding.
package rdysetgo_pkg;

  localparam logic [3:0] CH_R = 4'b1010;
  localparam logic [3:0] CH_D = 4'b0100;
  localparam logic [3:0] CH_Y = 4'b1100;
  localparam logic [3:0] CH_G = 4'b1011;
  localparam logic [3:0] CH_O = 4'b1110;

  localparam int MODE_WORDS = 0;
  localparam int MODE_COUNT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nsteps(input int mode, input int count_from);
    return (mode == MODE_COUNT) ? count_from + 1 : 2;
  endfunction

endpackage

// File: rtl/rdysetgo_frame_rom.sv
// Combinational frame table: maps a step index to per-digit codes and a
// blank mask. The last step is always "GO"; earlier steps depend on MODE.
module rdysetgo_frame_rom
  import rdysetgo_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CODE_W     = 4,
  parameter int MODE       = 0,
  parameter int COUNT_FROM = 3,
  parameter int SW         = 1
) (
  input  logic [SW-1:0]            step_i,
  output logic [DIGITS*CODE_W-1:0] digits_o,
  output logic [DIGITS-1:0]        blank_o
);

  localparam int NSTEPS = nsteps(MODE, COUNT_FROM);
  localparam logic [SW-1:0] LAST = SW'(NSTEPS - 1);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      logic [CODE_W-1:0] code;
      logic              off;

      always_comb begin
        code = '0;
        off  = 1'b1;
        if (step_i == LAST) begin
          if (gi == 1) begin
            code = CODE_W'(CH_G);
            off  = 1'b0;
          end else if (gi == 0) begin
            code = CODE_W'(CH_O);
            off  = 1'b0;
          end
        end else if (MODE == MODE_WORDS) begin
          if (gi == 2) begin
            code = CODE_W'(CH_R);
            off  = 1'b0;
          end else if (gi == 1) begin
            code = CODE_W'(CH_D);
            off  = 1'b0;
          end else if (gi == 0) begin
            code = CODE_W'(CH_Y);
            off  = 1'b0;
          end
        end else if (gi == 0) begin
          code = CODE_W'(COUNT_FROM - int'(step_i));
          off  = 1'b0;
        end
      end

      assign digits_o[gi*CODE_W +: CODE_W] = code;
      assign blank_o[gi]                   = off;
    end
  endgenerate

endmodule

// File: rtl/rdysetgo_seq.sv
// Start-of-round display sequencer: on a start rising edge, plays a timed
// series of frames ending in "GO", then holds DONE until start drops.
module rdysetgo_seq
  import rdysetgo_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CODE_W         = 4,
  parameter int TICKS_PER_STEP = 100000000,
  parameter int MODE           = 0,
  parameter int COUNT_FROM     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [DIGITS*CODE_W-1:0] digits,
  output logic [DIGITS-1:0]        blank,
  output logic                     busy,
  output logic                     go_pulse,
  output logic                     done
);

  localparam int NSTEPS = nsteps(MODE, COUNT_FROM);
  localparam int SW     = $clog2(NSTEPS);
  localparam int CW     = $clog2(TICKS_PER_STEP + 1);
  localparam logic [SW-1:0] LAST = SW'(NSTEPS - 1);
  localparam logic [CW-1:0] TC   = CW'(TICKS_PER_STEP - 1);

  state_e                   state_q, state_d;
  logic [SW-1:0]            step_q, step_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     start_q;
  logic [DIGITS*CODE_W-1:0] digits_q, digits_d, rom_digits;
  logic [DIGITS-1:0]        blank_q, blank_d, rom_blank;
  logic                     busy_q, busy_d, go_q, go_d, done_q, done_d;

  rdysetgo_frame_rom #(
    .DIGITS    (DIGITS),
    .CODE_W    (CODE_W),
    .MODE      (MODE),
    .COUNT_FROM(COUNT_FROM),
    .SW        (SW)
  ) u_rom (
    .step_i  (step_d),
    .digits_o(rom_digits),
    .blank_o (rom_blank)
  );

  // start_q comes out of reset high so a start already held high is not a launch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b1;
      digits_q <= '0;
      blank_q  <= '1;
      busy_q   <= 1'b0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      start_q  <= start;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      go_q     <= go_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          state_d = RUN;
          step_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!start) begin
          state_d = IDLE;
          step_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == TC) begin
          cnt_d = '0;
          if (step_q == LAST) begin
            state_d = DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are precomputed from the next state so the registers show the frame of the current step.
  always_comb begin
    digits_d = '0;
    blank_d  = '1;
    busy_d   = (state_d == RUN);
    done_d   = (state_d == DONE);
    go_d     = (state_d == RUN) && (step_d == LAST) &&
               !((state_q == RUN) && (step_q == LAST));
    if (state_d == RUN) begin
      digits_d = rom_digits;
      blank_d  = rom_blank;
    end
  end

  assign digits   = digits_q;
  assign blank    = blank_q;
  assign busy     = busy_q;
  assign go_pulse = go_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rdysetgo_seq.sv
// Bench for rdysetgo_seq: three configurations share clk/reset/start and are
// checked every cycle against an elapsed-time model, plus literal spot checks.
module tb_rdysetgo_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] dig_a, dig_b;
  logic [23:0] dig_c;
  logic [3:0]  blk_a, blk_b;
  logic [5:0]  blk_c;
  logic busy_a, busy_b, busy_c, go_a, go_b, go_c, done_a, done_b, done_c;

  rdysetgo_seq #(.DIGITS(4), .CODE_W(4), .TICKS_PER_STEP(4), .MODE(0), .COUNT_FROM(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .digits(dig_a), .blank(blk_a),
    .busy(busy_a), .go_pulse(go_a), .done(done_a));
  rdysetgo_seq #(.DIGITS(4), .CODE_W(4), .TICKS_PER_STEP(2), .MODE(1), .COUNT_FROM(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .digits(dig_b), .blank(blk_b),
    .busy(busy_b), .go_pulse(go_b), .done(done_b));
  rdysetgo_seq #(.DIGITS(6), .CODE_W(4), .TICKS_PER_STEP(1), .MODE(0), .COUNT_FROM(3)) dut_c (
    .clk(clk), .reset(reset), .start(start), .digits(dig_c), .blank(blk_c),
    .busy(busy_c), .go_pulse(go_c), .done(done_c));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per configuration, phase (0 idle, 1 run, 2 done) and cycles elapsed since launch.
  int NDIG[3] = '{4, 4, 6};
  int TK[3]   = '{4, 2, 1};
  int MD[3]   = '{0, 1, 0};
  int NS[3]   = '{2, 4, 2};
  int phase[3] = '{0, 0, 0};
  int t[3]     = '{0, 0, 0};
  logic prev_start = 1'b1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        phase[d] = 0;
        t[d] = 0;
      end
      prev_start = 1'b1;
    end else begin
      for (int d = 0; d < 3; d++) begin
        case (phase[d])
          0: if (start && !prev_start) begin phase[d] = 1; t[d] = 0; end
          1: if (!start) phase[d] = 0;
             else begin
               t[d]++;
               if (t[d] == NS[d] * TK[d]) phase[d] = 2;
             end
          default: if (!start) phase[d] = 0;
        endcase
      end
      prev_start = start;
    end
  end

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      logic [31:0] ed, ad;
      logic [7:0]  eb, ab, mask;
      logic        ebusy, ego, edone, abusy, ago, adone;
      int          fr;
      mask  = 8'((1 << NDIG[d]) - 1);
      ed    = 32'h0;
      eb    = mask;
      ebusy = (phase[d] == 1);
      edone = (phase[d] == 2);
      ego   = (phase[d] == 1) && (t[d] == (NS[d] - 1) * TK[d]);
      if (phase[d] == 1) begin
        fr = t[d] / TK[d];
        if (fr == NS[d] - 1) begin
          ed = 32'h0000_00BE;
          eb = mask & 8'hFC;
        end else if (MD[d] == 0) begin
          ed = 32'h0000_0A4C;
          eb = mask & 8'hF8;
        end else begin
          ed = 32'(3 - fr);
          eb = mask & 8'hFE;
        end
      end
      case (d)
        0: begin ad = {16'h0, dig_a}; ab = {4'h0, blk_a}; abusy = busy_a; ago = go_a; adone = done_a; end
        1: begin ad = {16'h0, dig_b}; ab = {4'h0, blk_b}; abusy = busy_b; ago = go_b; adone = done_b; end
        default: begin ad = {8'h0, dig_c}; ab = {2'h0, blk_c}; abusy = busy_c; ago = go_c; adone = done_c; end
      endcase
      check($sformatf("model%0d.digits", d), ad, ed);
      check($sformatf("model%0d.blank", d), {24'h0, ab}, {24'h0, eb});
      check($sformatf("model%0d.busy", d), {31'h0, abusy}, {31'h0, ebusy});
      check($sformatf("model%0d.go", d), {31'h0, ago}, {31'h0, ego});
      check($sformatf("model%0d.done", d), {31'h0, adone}, {31'h0, edone});
    end
  endtask

  always @(negedge clk) compare_all();

  initial begin
    // reset held with start high
    repeat (3) @(negedge clk);
    check("rst.dig_a", {16'h0, dig_a}, 32'h0);
    check("rst.blk_a", {28'h0, blk_a}, 32'hF);
    check("rst.flags_a", {29'h0, busy_a, go_a, done_a}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.nolaunch", {31'h0, busy_a}, 32'h0);

    // full sequence on all three configurations
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          check("seq.a_rdy", {16'h0, dig_a}, 32'h0A4C);
          check("seq.a_blk", {28'h0, blk_a}, 32'h8);
          check("seq.b_3", {16'h0, dig_b}, 32'h0003);
          check("seq.b_blk", {28'h0, blk_b}, 32'hE);
          check("seq.c_rdy", {8'h0, dig_c}, 32'h000A4C);
          check("seq.c_blk", {26'h0, blk_c}, 32'h38);
        end
        2: begin
          check("seq.c_go", {31'h0, go_c}, 32'h1);
          check("seq.c_godig", {8'h0, dig_c}, 32'h0000BE);
          check("seq.c_goblk", {26'h0, blk_c}, 32'h3C);
        end
        3: begin
          check("seq.c_go_once", {31'h0, go_c}, 32'h0);
          check("seq.c_done", {31'h0, done_c}, 32'h1);
          check("seq.b_2", {16'h0, dig_b}, 32'h0002);
        end
        4: check("seq.a_rdy_last", {15'h0, go_a, dig_a}, 32'h0A4C);
        5: begin
          check("seq.a_go", {31'h0, go_a}, 32'h1);
          check("seq.a_godig", {16'h0, dig_a}, 32'h00BE);
          check("seq.a_goblk", {28'h0, blk_a}, 32'hC);
          check("seq.b_1", {16'h0, dig_b}, 32'h0001);
        end
        6: check("seq.a_go_once", {31'h0, go_a}, 32'h0);
        7: begin
          check("seq.b_go", {31'h0, go_b}, 32'h1);
          check("seq.b_godig", {16'h0, dig_b}, 32'h00BE);
        end
        8: check("seq.b_busy", {30'h0, busy_b, go_b}, 32'h2);
        9: begin
          check("seq.a_done", {27'h0, done_a, blk_a}, 32'h1F);
          check("seq.b_done", {31'h0, done_b}, 32'h1);
        end
        default: ;
      endcase
    end
    start = 1'b0;
    @(negedge clk);
    check("seq.c_done_clr", {31'h0, done_c}, 32'h0);

    // abort during the second GO cycle of configuration A
    start = 1'b1;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort.a_blk", {28'h0, blk_a}, 32'hF);
    check("abort.a_flags", {29'h0, busy_a, go_a, done_a}, 32'h0);
    repeat (12) @(negedge clk);
    check("abort.a_nodone", {31'h0, done_a}, 32'h0);

    // asynchronous reset during step 0
    start = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("arst.dig_a", {16'h0, dig_a}, 32'h0);
    check("arst.blk_a", {27'h0, busy_a, blk_a}, 32'hF);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("arst.nolaunch", {31'h0, busy_a}, 32'h0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) check($sformatf("arst.rdy%0d", k), {16'h0, dig_a}, 32'h0A4C);
      else check("arst.go", {31'h0, go_a}, 32'h1);
    end

    // randomized start activity with occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) start = ~start;
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
